subckt_stim_capture: RTL and testbench

- Sequential test harness for the small combinational power-experiment sub-circuits.
- Generates LFSR pseudo-random input vectors and drives them into the sub-circuit.
- Captures the sub-circuit's response into a MISR signature.
- Counts input and output toggles as a switching-activity proxy for power comparison before and after a rewrite.

---
 rtl/subckt_harness_pkg.sv | 43 ++++
 rtl/lfsr_misr.sv | 52 +++++
 rtl/subckt_stim_capture.sv | 186 ++++++++++++++++++
 tb/tb_subckt_stim_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/subckt_harness_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subckt_harness_pkg
// Description : Shared types, constants and helpers for the sub-circuit
//               stimulus/capture harness.
// Revision    : 1.0 - initial release
// ============================================================================
package subckt_harness_pkg;

    localparam int          C_MAX_W        = 64;
    localparam logic [15:0] C_DEFAULT_POLY = 16'hB400;
    localparam logic [15:0] C_DEFAULT_SEED = 16'hACE1;
    localparam logic        C_MODE_LFSR    = 1'b0;
    localparam logic        C_MODE_MISR    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] popcount(input logic [C_MAX_W-1:0] x);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < C_MAX_W; i++) begin
            n = n + {7'd0, x[i]};
        end
        return n;
    endfunction

    // Clamps at the all-ones value of a 'width'-bit counter (width < C_MAX_W).
    function automatic logic [C_MAX_W-1:0] sat_add(input logic [C_MAX_W-1:0] a,
                                                   input logic [C_MAX_W-1:0] b,
                                                   input int                 width);
        logic [C_MAX_W-1:0] lim;
        logic [C_MAX_W-1:0] sum;
        lim = (C_MAX_W'(1) << width) - C_MAX_W'(1);
        sum = a + b;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_misr.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_misr
// Description : Shift register that steps either as a Fibonacci LFSR or as a
//               MISR absorbing din; load and advance may coincide.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_misr
    import subckt_harness_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = C_DEFAULT_POLY,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_step;

    // With load and en together the step is taken from load_val.
    always_comb begin
        w_base = load ? load_val : r_q;
        if (mode == C_MODE_MISR) begin
            w_step = (w_base << 1) ^ (w_base[WIDTH-1] ? POLY : '0) ^ din;
        end else begin
            w_step = {w_base[WIDTH-2:0], ^(w_base & POLY)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (en) begin
            r_q <= w_step;
        end else if (load) begin
            r_q <= load_val;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/subckt_stim_capture.sv
`default_nettype none
// ============================================================================
// Module      : subckt_stim_capture
// Description : Drives LFSR vectors into a combinational sub-circuit, folds
//               its response into a MISR and counts input/output toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module subckt_stim_capture
    import subckt_harness_pkg::*;
#(
    parameter int                N_IN   = 4,
    parameter int                N_OUT  = 1,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] POLY   = C_DEFAULT_POLY,
    parameter logic [LFSR_W-1:0] SEED   = C_DEFAULT_SEED,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vectors,
    output logic              busy,
    output logic              done,
    output logic [N_IN-1:0]   stim,
    input  logic [N_OUT-1:0]  resp,
    output logic [LFSR_W-1:0] signature,
    output logic [CNT_W-1:0]  in_toggles,
    output logic [CNT_W-1:0]  out_toggles,
    output logic [CNT_W-1:0]  vec_count
);

    localparam logic [LFSR_W-1:0] C_SEED = (SEED == '0) ? LFSR_W'(1) : SEED;

    state_t            r_state;
    state_t            w_state_next;
    logic [N_IN-1:0]   r_stim;
    logic [CNT_W-1:0]  r_in_toggles;
    logic [CNT_W-1:0]  r_out_toggles;
    logic [CNT_W-1:0]  r_vec_count;
    logic [CNT_W-1:0]  r_num_vectors;
    logic [N_OUT-1:0]  r_prev_resp;
    logic              r_first;
    logic [LFSR_W-1:0] w_lfsr;
    logic [N_IN-1:0]   w_next_vec;
    logic              w_last;
    logic              w_lfsr_load;
    logic              w_lfsr_adv;
    logic              w_misr_clear;
    logic              w_misr_adv;
    logic              w_unused_lfsr;

    assign w_next_vec    = w_lfsr[N_IN-1:0];
    assign w_last        = (r_vec_count == r_num_vectors);
    assign w_unused_lfsr = ^w_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lfsr_load  = 1'b0;
        w_lfsr_adv   = 1'b0;
        w_misr_clear = 1'b0;
        w_misr_adv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_misr_clear = 1'b1;
                    if (num_vectors != '0) begin
                        // Reload and step at once: vector0 is the seed itself.
                        w_lfsr_load  = 1'b1;
                        w_lfsr_adv   = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                w_misr_adv = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_lfsr_adv = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim        <= '0;
            r_in_toggles  <= '0;
            r_out_toggles <= '0;
            r_vec_count   <= '0;
            r_num_vectors <= '0;
            r_prev_resp   <= '0;
            r_first       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_num_vectors <= num_vectors;
                        r_in_toggles  <= '0;
                        r_out_toggles <= '0;
                        if (num_vectors != '0) begin
                            r_stim      <= C_SEED[N_IN-1:0];
                            r_vec_count <= CNT_W'(1);
                            r_first     <= 1'b1;
                        end else begin
                            r_vec_count <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_prev_resp <= resp;
                    r_first     <= 1'b0;
                    if (!r_first) begin
                        r_out_toggles <= CNT_W'(sat_add(C_MAX_W'(r_out_toggles),
                                             C_MAX_W'(popcount(C_MAX_W'(resp ^ r_prev_resp))),
                                             CNT_W));
                    end
                    if (!w_last) begin
                        r_stim       <= w_next_vec;
                        r_in_toggles <= CNT_W'(sat_add(C_MAX_W'(r_in_toggles),
                                            C_MAX_W'(popcount(C_MAX_W'(w_next_vec ^ r_stim))),
                                            CNT_W));
                        r_vec_count  <= r_vec_count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    lfsr_misr #(
        .WIDTH   (LFSR_W),
        .POLY    (POLY),
        .RST_VAL (C_SEED)
    ) u_stim_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_lfsr_load),
        .load_val (C_SEED),
        .en       (w_lfsr_adv),
        .mode     (C_MODE_LFSR),
        .din      ({LFSR_W{1'b0}}),
        .q        (w_lfsr)
    );

    lfsr_misr #(
        .WIDTH   (LFSR_W),
        .POLY    (POLY),
        .RST_VAL ({LFSR_W{1'b0}})
    ) u_sig_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_misr_clear),
        .load_val ({LFSR_W{1'b0}}),
        .en       (w_misr_adv),
        .mode     (C_MODE_MISR),
        .din      (LFSR_W'(resp)),
        .q        (signature)
    );

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign stim        = r_stim;
    assign in_toggles  = r_in_toggles;
    assign out_toggles = r_out_toggles;
    assign vec_count   = r_vec_count;

endmodule
`default_nettype wire

// File: tb/tb_subckt_stim_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_subckt_stim_capture
// Description : Self-checking bench: vector table, random truth tables
//               against a queue-based model, and abort/disturbance sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subckt_stim_capture;

    localparam logic [15:0] C_POLY = 16'hB400;
    localparam logic [15:0] C_SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_vectors;
    logic        busy;
    logic        done;
    logic [3:0]  stim;
    logic [0:0]  resp;
    logic [15:0] signature;
    logic [15:0] in_toggles;
    logic [15:0] out_toggles;
    logic [15:0] vec_count;

    int          resp_mode;
    logic [15:0] tt;
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    // Bench-side sub-circuit: 0/1 constants, the reference gate, or a truth table.
    function automatic logic resp_fn(input logic [3:0] s, input int m, input logic [15:0] t);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return s[0] & ((s[1] & s[3]) | (s[1] ^ s[2]));
            default: return t[s];
        endcase
    endfunction

    assign resp = resp_fn(stim, resp_mode, tt);

    subckt_stim_capture dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_vectors (num_vectors),
        .busy        (busy),
        .done        (done),
        .stim        (stim),
        .resp        (resp),
        .signature   (signature),
        .in_toggles  (in_toggles),
        .out_toggles (out_toggles),
        .vec_count   (vec_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input int nv, input int mode, input logic [15:0] t,
                         output logic [15:0] sig, output logic [15:0] in_t,
                         output logic [15:0] out_t, output logic [3:0] last);
        logic [15:0] l;
        logic [3:0]  v[$];
        int          si;
        int          so;
        logic        r;
        logic        rp;
        l = C_SEED;
        for (int i = 0; i < nv; i++) begin
            v.push_back(l[3:0]);
            l = {l[14:0], ^(l & C_POLY)};
        end
        sig  = '0;
        si   = 0;
        so   = 0;
        rp   = 1'b0;
        last = '0;
        foreach (v[i]) begin
            r   = resp_fn(v[i], mode, t);
            sig = {sig[14:0], 1'b0} ^ (sig[15] ? C_POLY : 16'h0) ^ {15'h0, r};
            if (i > 0) begin
                si += $countones(v[i] ^ v[i-1]);
                so += int'(r != rp);
            end
            rp   = r;
            last = v[i];
        end
        in_t  = (si > 65535) ? 16'hFFFF : 16'(si);
        out_t = (so > 65535) ? 16'hFFFF : 16'(so);
    endtask

    task automatic run_check(input string tag, input int nv, input int mode, input logic [15:0] t,
                             input bit disturb, input logic [15:0] e_sig, input logic [15:0] e_in,
                             input logic [15:0] e_out, input logic [15:0] e_vc, input logic [3:0] e_last);
        int         lat;
        bit         busy_seen;
        logic [3:0] exp_stim;
        @(negedge clk);
        resp_mode   = mode;
        tt          = t;
        num_vectors = 16'(nv);
        start       = 1'b1;
        exp_stim    = (nv == 0) ? stim : e_last;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lat       = 0;
        busy_seen = busy;
        while (!done && lat < nv + 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_seen = 1'b1;
            if (disturb && lat == 1) begin
                start       = 1'b1;
                num_vectors = 16'd3;
            end
            if (disturb && lat == 2) begin
                start       = 1'b0;
                num_vectors = 16'd20;
            end
        end
        check({tag, " done latency"}, 64'(lat), 64'(nv));
        check({tag, " busy seen"}, 64'(busy_seen), 64'(nv != 0));
        check({tag, " signature"}, 64'(signature), 64'(e_sig));
        check({tag, " in_toggles"}, 64'(in_toggles), 64'(e_in));
        check({tag, " out_toggles"}, 64'(out_toggles), 64'(e_out));
        check({tag, " vec_count"}, 64'(vec_count), 64'(e_vc));
        check({tag, " stim"}, 64'(stim), 64'(exp_stim));
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, 64'({done, busy}), 64'd0);
        check({tag, " results hold"}, 64'({signature, vec_count}), 64'({e_sig, e_vc}));
    endtask

    typedef struct {
        int          nv;
        int          mode;
        logic [15:0] sig;
        logic [15:0] in_t;
        logic [15:0] out_t;
        logic [15:0] vc;
        logic [3:0]  last;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [15:0] m_sig;
        logic [15:0] m_in;
        logic [15:0] m_out;
        logic [3:0]  m_last;
        logic [15:0] t;
        int          nv;
        bit          seen;

        tbl[0] = '{2, 0, 16'h0000, 16'd1, 16'd0, 16'd2, 4'h3};
        tbl[1] = '{2, 1, 16'h0003, 16'd1, 16'd0, 16'd2, 4'h3};
        tbl[2] = '{2, 2, 16'h0001, 16'd1, 16'd1, 16'd2, 4'h3};
        tbl[3] = '{1, 1, 16'h0001, 16'd0, 16'd0, 16'd1, 4'h1};
        tbl[4] = '{0, 1, 16'h0000, 16'd0, 16'd0, 16'd0, 4'h0};

        rst         = 1'b1;
        start       = 1'b0;
        num_vectors = '0;
        resp_mode   = 1;
        tt          = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset stim", 64'(stim), 64'd0);
        check("reset signature", 64'(signature), 64'd0);
        check("reset counters", 64'({in_toggles, out_toggles, vec_count}), 64'd0);
        check("reset busy/done", 64'({busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_check($sformatf("tbl%0d", i), tbl[i].nv, tbl[i].mode, 16'h0, 1'b0,
                      tbl[i].sig, tbl[i].in_t, tbl[i].out_t, tbl[i].vc, tbl[i].last);
        end

        for (int k = 0; k < 8; k++) begin
            nv = int'($urandom_range(1, 40));
            t  = 16'($urandom);
            model(nv, 3, t, m_sig, m_in, m_out, m_last);
            run_check($sformatf("rand%0d", k), nv, 3, t, 1'b0, m_sig, m_in, m_out, 16'(nv), m_last);
        end

        // Start and num_vectors changes during RUN must be ignored.
        model(6, 2, 16'h0, m_sig, m_in, m_out, m_last);
        run_check("disturb", 6, 2, 16'h0, 1'b1, m_sig, m_in, m_out, 16'd6, m_last);

        // Long run pushes in_toggles toward saturation.
        t = 16'($urandom);
        model(40000, 3, t, m_sig, m_in, m_out, m_last);
        run_check("long", 40000, 3, t, 1'b0, m_sig, m_in, m_out, 16'd40000, m_last);

        // Abort mid-run with reset.
        @(negedge clk);
        resp_mode   = 2;
        num_vectors = 16'd5;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort outputs", 64'({stim, signature, in_toggles, out_toggles}), 64'd0);
        check("abort vec_count/busy/done", 64'({vec_count, busy, done}), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort no done", 64'(seen), 64'd0);
        run_check("after abort", tbl[0].nv, tbl[0].mode, 16'h0, 1'b0,
                  tbl[0].sig, tbl[0].in_t, tbl[0].out_t, tbl[0].vc, tbl[0].last);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
